// File: rtl/shared_mem_interconnect.sv
// rtl/shared_mem_interconnect.sv - N-port arbiter/router onto global memory and a device window
// Optional macro SHARED_MEM_LOCK_EN adds req_lock so a granted port can hold the grant.
module shared_mem_interconnect #(
    parameter int NUM_PORTS       = 8,
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 16,
    parameter int GMEM_ADDR_WIDTH = 10,
    parameter int DEV_ADDR_WIDTH  = 10,
    parameter int ARB_MODE        = 1,
    localparam int PW             = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS-1:0]             req_wren,
    input  logic [NUM_PORTS-1:0]             req_rden,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
`ifdef SHARED_MEM_LOCK_EN
    input  logic [NUM_PORTS-1:0]             req_lock,
`endif
    output logic [NUM_PORTS-1:0]             grant_oh,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic [NUM_PORTS-1:0]             rdata_valid_oh,
    output logic [GMEM_ADDR_WIDTH-1:0]       gmem_addr,
    output logic                             gmem_we,
    output logic [DATA_WIDTH-1:0]            gmem_wdata,
    input  logic [DATA_WIDTH-1:0]            gmem_q,
    output logic [PW-1:0]                    device_port_id,
    output logic                             device_write_en,
    output logic                             device_read_en,
    output logic [DEV_ADDR_WIDTH-1:0]        device_addr,
    output logic [DATA_WIDTH-1:0]            device_data_out,
    input  logic [DATA_WIDTH-1:0]            device_data_in
);

    logic [PW-1:0]           gidx;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    sel_wren;
    logic                    sel_rden;
    logic                    dev_sel;
    logic                    dev_sel_q;
    logic                    rd_issue;
    logic [NUM_PORTS-1:0]    active;
    logic [NUM_PORTS-1:0]    next_grant;
    logic [PW-1:0]           cand;
    logic                    found;

    always_comb begin
        gidx      = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wren  = 1'b0;
        sel_rden  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_oh[i]) begin
                gidx      = PW'(i);
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_wren  = req_wren[i];
                sel_rden  = req_rden[i];
            end
        end
    end

    assign dev_sel  = &sel_addr[ADDR_WIDTH-1:DEV_ADDR_WIDTH];
    assign rd_issue = sel_rden & ~sel_wren;

    // Strobes are forced low while reset is held even though grant sits on port 0.
    assign gmem_we         = ~reset & sel_wren & ~dev_sel;
    assign device_write_en = ~reset & sel_wren & dev_sel;
    assign device_read_en  = ~reset & rd_issue & dev_sel;
    assign gmem_addr       = sel_addr[GMEM_ADDR_WIDTH-1:0];
    assign gmem_wdata      = sel_wdata;
    assign device_addr     = sel_addr[DEV_ADDR_WIDTH-1:0];
    assign device_data_out = sel_wdata;
    assign device_port_id  = gidx;
    assign rdata           = dev_sel_q ? device_data_in : gmem_q;

    assign active = req_wren | req_rden;

    // Round-robin scan starts after the current port, so it is visited last.
    always_comb begin
        next_grant = grant_oh;
        cand       = gidx;
        found      = 1'b0;
        if (ARB_MODE == 0) begin
            next_grant = {grant_oh[NUM_PORTS-2:0], grant_oh[NUM_PORTS-1]};
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                cand = (cand == PW'(NUM_PORTS-1)) ? '0 : cand + 1'b1;
                if (!found && active[cand]) begin
                    found            = 1'b1;
                    next_grant       = '0;
                    next_grant[cand] = 1'b1;
                end
            end
        end
`ifdef SHARED_MEM_LOCK_EN
        if (req_lock[gidx]) begin
            next_grant = grant_oh;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_oh       <= {{(NUM_PORTS-1){1'b0}}, 1'b1};
            rdata_valid_oh <= '0;
            dev_sel_q      <= 1'b0;
        end else begin
            grant_oh <= next_grant;
            if (rd_issue) begin
                rdata_valid_oh <= grant_oh;
                dev_sel_q      <= dev_sel;
            end else begin
                rdata_valid_oh <= '0;
            end
        end
    end

endmodule

// File: doc/shared_mem_interconnect.md
Name: shared_mem_interconnect

Overview:
Parametrised arbiter and router between N core request ports and one shared global-memory and device address space. Each cycle it grants one port and forwards that port's access either to the global memory macro or to the memory-mapped device window. It also returns read data with a one-hot valid to the requester. Arbitration mode is selectable: fixed rotating time-slice, or work-conserving round-robin over requesters.

Parameters:
NUM_PORTS, 8, number of requester ports (2..16)
ADDR_WIDTH, 16, request address width
DATA_WIDTH, 16, data width
GMEM_ADDR_WIDTH, 10, global memory address bits (low bits of address)
DEV_ADDR_WIDTH, 10, device window address bits; window = upper ADDR_WIDTH-DEV_ADDR_WIDTH bits all ones
ARB_MODE, 1, 0 = static rotate every cycle, 1 = round-robin over active requests

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_addr  in  NUM_PORTS*ADDR_WIDTH  per-port address, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wren  in  NUM_PORTS  per-port write request
req_rden  in  NUM_PORTS  per-port read request
req_wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data
grant_oh  out  NUM_PORTS  registered one-hot grant; port i may issue while grant_oh[i]=1
rdata  out  DATA_WIDTH  read data, broadcast to all ports
rdata_valid_oh  out  NUM_PORTS  registered one-hot; rdata valid for port i this cycle
gmem_addr  out  GMEM_ADDR_WIDTH  memory address
gmem_we  out  1  memory write enable
gmem_wdata  out  DATA_WIDTH  memory write data
gmem_q  in  DATA_WIDTH  memory read data, 1-cycle synchronous latency
device_port_id  out  $clog2(NUM_PORTS)  index of the granted port
device_write_en  out  1  device write strobe
device_read_en  out  1  device read strobe
device_addr  out  DEV_ADDR_WIDTH  device address
device_data_out  out  DATA_WIDTH  device write data
device_data_in  in  DATA_WIDTH  device read data, valid one cycle after device_read_en

Behaviour:
- Reset values: grant_oh = 1 (port 0), rdata_valid_oh = 0, registered select flag = 0. All strobes are 0 while reset is held.
- Request path (combinational from grant_oh):
  - Muxes the granted port's addr, wren, rden and wdata.
  - dev_sel = (upper address bits all ones).
  - gmem_we = wren & !dev_sel.
  - device_write_en = wren & dev_sel.
  - device_read_en = rden & !wren & dev_sel.
  - gmem_addr and device_addr are the low address bits.
- Requests without grant are ignored. The port holds its request until it sees its grant bit.
- wren and rden asserted together is treated as a write only. No read response is produced.
- Response path:
  - At a clock edge where the granted port asserts rden & !wren, rdata_valid_oh <= grant_oh and dev_sel is registered.
  - Otherwise rdata_valid_oh <= 0.
  - The next cycle, rdata = registered dev_sel ? device_data_in : gmem_q.
  - Read latency is exactly 1 cycle after the issuing edge.
- ARB_MODE 0: grant_oh rotates left by one every cycle, wrapping from port NUM_PORTS-1 to port 0, regardless of requests.
- ARB_MODE 1:
  - active = req_wren | req_rden.
  - The next grant is the first active port scanning from (current index + 1) mod NUM_PORTS, wrapping.
  - The current port is considered last, so it is re-granted only if it is the sole requester.
  - If no port is active, grant_oh holds.
  - A port issuing continuously while others wait loses the grant after one access.
- Back-to-back reads from different ports produce consecutive rdata_valid_oh bits with no bubble.
- Reset asserted mid-read: the pending valid is cleared immediately and the response is dropped.
- Grant updates every cycle. No multi-cycle stalls (except in the optional feature below).

Optional Feature:
Macro SHARED_MEM_LOCK_EN.
- Defined: adds input port req_lock [NUM_PORTS].
  - If the granted port asserts req_lock at an edge, grant_oh holds on that port in both modes. This permits atomic read-modify-write.
  - The lock releases when req_lock drops. Non-granted ports' lock bits are ignored.
- Undefined: no req_lock port; arbitration exactly as above.

Test Plan:
- Reset, ARB_MODE=0, no requests -> grant_oh sequence 0x01,0x02,...,0x80,0x01; all strobes 0.
- ARB_MODE=1, only port 5 rden addr 0x0010, gmem_q=0xBEEF -> grant moves to 0x20 in 1 cycle, issues, rdata_valid_oh=0x20 and rdata=0xBEEF one cycle later; grant stays 0x20.
- ARB_MODE=1, ports 0,3,7 requesting continuously from grant 0x01 -> grants 0x08,0x80,0x01,0x08; each port gets 1 of every 3 slots.
- Port 2 writes 0x1234 to 0xFC05 -> device_write_en=1, device_addr=0x005, device_port_id=2, gmem_we=0; read of 0xFC05 with device_data_in=0xA5A5 -> rdata=0xA5A5.
- Port 1 asserts wren and rden together at 0x0003 -> gmem_we=1, no rdata_valid_oh; reset pulsed the cycle after a read issue -> rdata_valid_oh=0, grant_oh=0x01.
- SHARED_MEM_LOCK_EN: port 4 locked with 3 others requesting -> grant_oh stays 0x10 for 4 cycles; after lock drop, next requester after port 4 is granted.
